// File: rtl/channel_debug_monitor.sv
// channel_debug_monitor
//
// Multi-channel debug display engine for the DE2 top level. Each channel has
// a snapshot register, an 8-bit update counter and an age counter used for
// staleness detection. A debounced pushbutton and an optional timed
// auto-scroll choose which channel is shown. Every output is registered and
// already carries a leading-zero blank mask for the hex digit drivers.
//
// Ports:
//   clk          - the only clock, rising edge
//   reset        - synchronous, active-high reset
//   value_valid  - per-channel capture strobe [NUM_CH]
//   values       - packed channel values, channel c at [c*VAL_WIDTH +: VAL_WIDTH]
//   freeze       - level; holds all captures and update counters while high
//   key_next_n   - raw active-low pushbutton, asynchronous to clk
//   auto_scroll  - level; enables timed channel advance
//   sel_ch       - currently selected channel
//   disp_value   - snapshot of the selected channel
//   blank_mask   - bit d set blanks hex digit d (leading zeros)
//   upd_count    - update counter of the selected channel
//   stale        - selected channel has had no capture for STALE_CYCLES clocks
module channel_debug_monitor #(
  parameter  int NUM_CH          = 4,
  parameter  int VAL_WIDTH       = 18,
  parameter  int HOLD_CYCLES     = 50_000_000,
  parameter  int DEBOUNCE_CYCLES = 1_000_000,
  parameter  int STALE_CYCLES    = 100_000_000,
  localparam int SEL_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NDIG            = (VAL_WIDTH + 3) / 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           value_valid,
  input  logic [NUM_CH*VAL_WIDTH-1:0] values,
  input  logic                        freeze,
  input  logic                        key_next_n,
  input  logic                        auto_scroll,
  output logic [SEL_W-1:0]            sel_ch,
  output logic [VAL_WIDTH-1:0]        disp_value,
  output logic [NDIG-1:0]             blank_mask,
  output logic [7:0]                  upd_count,
  output logic                        stale
);

  localparam int AGE_W   = $clog2(STALE_CYCLES + 1);
  localparam int DWELL_W = $clog2(HOLD_CYCLES + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [AGE_W-1:0]   AGE_MAX   = AGE_W'(STALE_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_END    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_CH - 1);

  // Per-channel state
  logic [VAL_WIDTH-1:0] snap [NUM_CH];
  logic [7:0]           cnt  [NUM_CH];
  logic [AGE_W-1:0]     age  [NUM_CH];

  // Key path
  logic            key_sync1;
  logic            key_sync2;
  logic            kdb;
  logic            kdb_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // Auto-scroll
  logic [DWELL_W-1:0] dwell;
  logic               tick;

  // Formatting of the selected snapshot
  logic [NDIG*4-1:0] padded;
  logic [NDIG-1:0]   mask_next;
  logic              all_zero;

  // Capture and aging for every channel. A capture resets the channel's age;
  // freeze blocks captures but deliberately lets ages keep running so a
  // frozen display still reports channels that have gone quiet.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        snap[c] <= '0;
        cnt[c]  <= '0;
        age[c]  <= '0;
      end else if (value_valid[c] && !freeze) begin
        snap[c] <= values[c*VAL_WIDTH +: VAL_WIDTH];
        cnt[c]  <= cnt[c] + 8'd1;
        age[c]  <= '0;
      end else if (age[c] != AGE_MAX) begin
        age[c]  <= age[c] + AGE_W'(1);
      end
    end
  end

  // Two-flop synchroniser followed by the debouncer. The level flips on the
  // edge at which the mismatch counter would reach DEBOUNCE_CYCLES, so kdb
  // changes exactly DEBOUNCE_CYCLES clocks after the synchronised key first
  // differs. kdb_prev lets us pick out the single 1->0 transition as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync1 <= 1'b0;
      key_sync2 <= 1'b0;
      kdb       <= 1'b1;
      kdb_prev  <= 1'b1;
      db_cnt    <= '0;
    end else begin
      key_sync1 <= key_next_n;
      key_sync2 <= key_sync1;
      kdb_prev  <= kdb;
      if (key_sync2 != kdb) begin
        if (db_cnt == DB_END) begin
          kdb    <= key_sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = kdb_prev && !kdb;
  assign tick  = auto_scroll && (dwell == DWELL_END);

  // Dwell counter and channel selection. A press restarts the dwell so the
  // user gets a full dwell period on the channel they chose. Press and tick
  // together are OR-ed, so they can only ever advance by one channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell  <= '0;
      sel_ch <= '0;
    end else begin
      if (press || !auto_scroll || tick) begin
        dwell <= '0;
      end else begin
        dwell <= dwell + DWELL_W'(1);
      end
      if (press || tick) begin
        sel_ch <= (sel_ch == SEL_LAST) ? '0 : sel_ch + SEL_W'(1);
      end
    end
  end

  // Leading-zero mask for the selected snapshot. Walking from the top digit
  // down, a digit is blanked while every digit from it upward is zero.
  // Digit 0 is never blanked so a zero value still shows a single '0'.
  always_comb begin
    padded                 = '0;
    padded[VAL_WIDTH-1:0]  = snap[sel_ch];
    mask_next              = '0;
    all_zero               = 1'b1;
    for (int d = NDIG - 1; d >= 1; d--) begin
      all_zero     = all_zero && (padded[d*4 +: 4] == 4'h0);
      mask_next[d] = all_zero;
    end
  end

  // Output registers: one clock behind sel_ch and the per-channel state, so
  // a channel switch shows the old channel for one more cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_value <= '0;
      upd_count  <= '0;
      stale      <= 1'b0;
      blank_mask <= {{(NDIG-1){1'b1}}, 1'b0};
    end else begin
      disp_value <= snap[sel_ch];
      upd_count  <= cnt[sel_ch];
      stale      <= (age[sel_ch] == AGE_MAX);
      blank_mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_channel_debug_monitor.sv
// Directed testbench for channel_debug_monitor with small timing parameters
// (NUM_CH=4, VAL_WIDTH=18, HOLD=8, DEBOUNCE=4, STALE=16). Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point.
module tb_channel_debug_monitor;

  localparam int NUM_CH    = 4;
  localparam int VAL_WIDTH = 18;
  localparam int NDIG      = 5;

  logic                        clk;
  logic                        reset;
  logic [NUM_CH-1:0]           value_valid;
  logic [NUM_CH*VAL_WIDTH-1:0] values;
  logic                        freeze;
  logic                        key_next_n;
  logic                        auto_scroll;
  logic [1:0]                  sel_ch;
  logic [VAL_WIDTH-1:0]        disp_value;
  logic [NDIG-1:0]             blank_mask;
  logic [7:0]                  upd_count;
  logic                        stale;

  int checks;
  int failures;

  channel_debug_monitor #(
    .NUM_CH(NUM_CH),
    .VAL_WIDTH(VAL_WIDTH),
    .HOLD_CYCLES(8),
    .DEBOUNCE_CYCLES(4),
    .STALE_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value_valid(value_valid),
    .values(values),
    .freeze(freeze),
    .key_next_n(key_next_n),
    .auto_scroll(auto_scroll),
    .sel_ch(sel_ch),
    .disp_value(disp_value),
    .blank_mask(blank_mask),
    .upd_count(upd_count),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold the given strobe pattern for a number of cycles, then drop it
  task automatic applyStimulus(input logic [NUM_CH-1:0] vld, input int cycles);
    value_valid = vld;
    stepCycles(cycles);
    value_valid = '0;
  endtask

  // Clean key press: sel_ch must change exactly 7 edges after key goes low
  // (2 sync + 4 debounce + 1 select), then release and let it settle
  task automatic pressAndCheck(input string tag, input logic [1:0] old_sel,
                               input logic [1:0] new_sel);
    key_next_n = 1'b0;
    stepCycles(6);
    checkOutput({tag, "_before"}, 32'(sel_ch), 32'(old_sel));
    stepCycles(1);
    checkOutput({tag, "_after"}, 32'(sel_ch), 32'(new_sel));
    key_next_n = 1'b1;
    stepCycles(8);
    checkOutput({tag, "_release"}, 32'(sel_ch), 32'(new_sel));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    value_valid = '0;
    values      = '0;
    freeze      = 1'b0;
    key_next_n  = 1'b1;
    auto_scroll = 1'b0;

    // Reset state
    stepCycles(3);
    checkOutput("rst_sel",   32'(sel_ch),     32'd0);
    checkOutput("rst_disp",  32'(disp_value), 32'd0);
    checkOutput("rst_upd",   32'(upd_count),  32'd0);
    checkOutput("rst_stale", 32'(stale),      32'd0);
    checkOutput("rst_blank", 32'(blank_mask), 32'b11110);
    reset = 1'b0;
    stepCycles(4);

    // Capture on ch1 and format after selecting it
    values[1*VAL_WIDTH +: VAL_WIDTH] = 18'h01234;
    applyStimulus(4'b0010, 1);
    pressAndCheck("press_ch1", 2'd0, 2'd1);
    checkOutput("cap_disp",  32'(disp_value), 32'h01234);
    checkOutput("cap_blank", 32'(blank_mask), 32'b10000);
    checkOutput("cap_upd",   32'(upd_count),  32'd1);

    // Get to ch2, run the dwell part way, then reset
    pressAndCheck("press_ch2", 2'd1, 2'd2);
    auto_scroll = 1'b1;
    stepCycles(3);
    checkOutput("mid_sel", 32'(sel_ch), 32'd2);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("mrst_sel",   32'(sel_ch),     32'd0);
    checkOutput("mrst_disp",  32'(disp_value), 32'd0);
    checkOutput("mrst_upd",   32'(upd_count),  32'd0);
    checkOutput("mrst_stale", 32'(stale),      32'd0);
    checkOutput("mrst_blank", 32'(blank_mask), 32'b11110);

    // Auto-scroll: exactly 8 clocks per channel, 0,1,2,3,0
    for (int i = 1; i <= 4; i++) begin
      stepCycles(7);
      checkOutput("auto_hold", 32'(sel_ch), 32'((i - 1) % 4));
      stepCycles(1);
      checkOutput("auto_step", 32'(sel_ch), 32'(i % 4));
    end

    // Press landing on the same edge as a tick advances only once
    stepCycles(1);
    key_next_n = 1'b0;
    stepCycles(6);
    checkOutput("coinc_before", 32'(sel_ch), 32'd0);
    stepCycles(1);
    checkOutput("coinc_single", 32'(sel_ch), 32'd1);
    key_next_n = 1'b1;
    stepCycles(7);
    checkOutput("coinc_hold", 32'(sel_ch), 32'd1);
    stepCycles(1);
    checkOutput("coinc_next", 32'(sel_ch), 32'd2);
    auto_scroll = 1'b0;
    stepCycles(2);

    // Debounce: three short glitches do nothing
    for (int g = 0; g < 3; g++) begin
      key_next_n = 1'b0;
      stepCycles(3);
      key_next_n = 1'b1;
      stepCycles(3);
    end
    stepCycles(10);
    checkOutput("glitch_sel", 32'(sel_ch), 32'd2);
    key_next_n = 1'b0;
    stepCycles(100);
    checkOutput("long_press", 32'(sel_ch), 32'd3);
    key_next_n = 1'b1;
    stepCycles(20);
    checkOutput("long_release", 32'(sel_ch), 32'd3);

    // Freeze blocks capture on ch0
    pressAndCheck("press_ch0", 2'd3, 2'd0);
    values[0 +: VAL_WIDTH] = 18'h3FFFF;
    freeze = 1'b1;
    applyStimulus(4'b0001, 1);
    stepCycles(2);
    checkOutput("frz_disp", 32'(disp_value), 32'd0);
    checkOutput("frz_upd",  32'(upd_count),  32'd0);
    freeze = 1'b0;
    stepCycles(1);

    // One capture, then 255 more wraps the counter to 0
    applyStimulus(4'b0001, 1);
    stepCycles(1);
    checkOutput("one_upd",   32'(upd_count),  32'd1);
    checkOutput("one_disp",  32'(disp_value), 32'h3FFFF);
    applyStimulus(4'b0001, 255);
    stepCycles(1);
    checkOutput("wrap_upd",   32'(upd_count),  32'd0);
    checkOutput("wrap_disp",  32'(disp_value), 32'h3FFFF);
    checkOutput("wrap_blank", 32'(blank_mask), 32'd0);

    // Staleness on ch0
    applyStimulus(4'b0001, 1);
    stepCycles(16);
    checkOutput("stale_early", 32'(stale), 32'd0);
    stepCycles(1);
    checkOutput("stale_rise", 32'(stale), 32'd1);
    applyStimulus(4'b0001, 1);
    checkOutput("stale_lag", 32'(stale), 32'd1);
    stepCycles(1);
    checkOutput("stale_clear", 32'(stale), 32'd0);
    freeze = 1'b1;
    stepCycles(15);
    checkOutput("frz_stale_early", 32'(stale), 32'd0);
    stepCycles(1);
    checkOutput("frz_stale_rise", 32'(stale), 32'd1);
    applyStimulus(4'b0001, 2);
    checkOutput("frz_stale_hold", 32'(stale),     32'd1);
    checkOutput("frz_upd_hold",   32'(upd_count), 32'd2);
    freeze = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
